// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int          KEY_W    = 4;
  localparam logic [3:0]  COL_IDLE = 4'b1110;

  // Lowest-numbered active-low row wins.
  function automatic logic [1:0] row_prio(input logic [3:0] row_n);
    logic [1:0] idx;
    idx = 2'd3;
    if (!row_n[2]) idx = 2'd2;
    if (!row_n[1]) idx = 2'd1;
    if (!row_n[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/kp_tick_div.sv
// Free-running prescaler: one-cycle tick every 2^SCAN_DIV_W clocks.
module kp_tick_div #(
  parameter int SCAN_DIV_W = 15
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  logic [SCAN_DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) div_cnt <= '0;
    else       div_cnt <= div_cnt + 1'b1;
  end

  assign tick = &div_cnt;

endmodule

// File: rtl/keypad4x4_scan.sv
// 4x4 active-low matrix keypad scanner with debounce and valid/ack key delivery.
// Define KEYPAD_DIGITBUF_EN to build the 8-digit key history on o_digits.
module keypad4x4_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 15,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       i_row,
  output logic [3:0]       o_col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic [31:0]      o_digits
);

  localparam logic [3:0] DT_C = 4'(DEBOUNCE_TICKS);

  logic             tick;
  logic [3:0]       row_p0, row_p1;
  kp_state_t        state, state_nxt;
  logic [1:0]       col_idx, col_nxt;
  logic [1:0]       row_idx, row_nxt;
  logic [3:0]       cnt, cnt_nxt, cnt_inc;
  logic [KEY_W-1:0] key_code_nxt;
  logic             key_valid_nxt;

  kp_tick_div #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick_div (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= i_row;
      row_p1 <= row_p0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cnt       <= 4'd0;
      key_code  <= '0;
      key_valid <= 1'b0;
      o_col     <= COL_IDLE;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      row_idx   <= row_nxt;
      cnt       <= cnt_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      o_col     <= ~(4'b0001 << col_nxt);
    end
  end

  always_comb begin
    state_nxt     = state;
    col_nxt       = col_idx;
    row_nxt       = row_idx;
    cnt_nxt       = cnt;
    key_code_nxt  = key_code;
    key_valid_nxt = key_valid;
    cnt_inc       = (cnt >= DT_C) ? DT_C : cnt + 4'd1;
    case (state)
      SCAN: begin
        if (tick) begin
          if (row_p1 != 4'hF) begin
            row_nxt = row_prio(row_p1);
            cnt_nxt = 4'd1;
            if (DT_C == 4'd1) begin
              key_code_nxt  = {row_prio(row_p1), col_idx};
              key_valid_nxt = 1'b1;
              state_nxt     = PRESS;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!row_p1[row_idx]) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DT_C) begin
              key_code_nxt  = {row_idx, col_idx};
              key_valid_nxt = 1'b1;
              state_nxt     = PRESS;
            end
          end else begin
            cnt_nxt   = 4'd0;
            col_nxt   = col_idx + 2'd1;
            state_nxt = SCAN;
          end
        end
      end
      PRESS: begin
        // Key stays latched even if released; only the consumer clears it.
        if (key_valid && key_ack) begin
          key_valid_nxt = 1'b0;
          cnt_nxt       = 4'd0;
          state_nxt     = RELEASE;
        end
      end
      RELEASE: begin
        if (tick) begin
          if (row_p1[row_idx]) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DT_C) begin
              cnt_nxt   = 4'd0;
              col_nxt   = col_idx + 2'd1;
              state_nxt = SCAN;
            end
          end else begin
            cnt_nxt = 4'd0;
          end
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

`ifdef KEYPAD_DIGITBUF_EN
  logic        key_push;
  logic [31:0] digits;

  assign key_push = key_valid_nxt & ~key_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         digits <= 32'h0;
    else if (key_push) digits <= {digits[27:0], key_code_nxt};
  end

  assign o_digits = digits;
`else
  assign o_digits = 32'h0;
`endif

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Directed bench for keypad4x4_scan with a combinational keypad matrix model.
module tb_keypad4x4_scan;

  logic        clk;
  logic        rstn;
  logic [3:0]  i_row;
  logic [3:0]  o_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic [31:0] o_digits;

  logic [15:0] keys;      // keys[row*4+col] = pressed
  logic        row_ovr;
  logic [3:0]  model_row;
  int          ec;
  int          checks;
  int          failures;

  keypad4x4_scan #(.SCAN_DIV_W(4), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_row     (i_row),
    .o_col     (o_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .o_digits  (o_digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    model_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !o_col[c]) model_row[r] = 1'b0;
    i_row = row_ovr ? 4'h0 : model_row;
  end

  task automatic step_to(input int e);
    while (ec < e) begin
      @(posedge clk);
      #1;
      ec++;
    end
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    keys    = 16'h0;
    key_ack = 1'b0;
    row_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    ec   = 0;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    row_ovr = 1'b1;
    keys    = 16'h0;
    key_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_col !== 4'b1110) begin failures++; $display("FAIL rst_col got=%b exp=1110", o_col); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL rst_code got=%h exp=0", key_code); end
    checks++; if (o_digits !== 32'h0) begin failures++; $display("FAIL rst_digits got=%h exp=0", o_digits); end
    row_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    ec   = 0;
    key_ack = 1'b1;   // ack with nothing pending must be ignored
    step_to(15);
    checks++; if (o_col !== 4'b1110) begin failures++; $display("FAIL scan_c15 got=%b exp=1110", o_col); end
    step_to(16);
    checks++; if (o_col !== 4'b1101) begin failures++; $display("FAIL scan_c16 got=%b exp=1101", o_col); end
    step_to(32);
    checks++; if (o_col !== 4'b1011) begin failures++; $display("FAIL scan_c32 got=%b exp=1011", o_col); end
    step_to(48);
    checks++; if (o_col !== 4'b0111) begin failures++; $display("FAIL scan_c48 got=%b exp=0111", o_col); end
    step_to(64);
    checks++; if (o_col !== 4'b1110) begin failures++; $display("FAIL scan_c64 got=%b exp=1110", o_col); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL scan_valid got=%b exp=0", key_valid); end
    key_ack = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    keys[2*4+1] = 1'b1;
    step_to(63);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press_early got=%b exp=0", key_valid); end
    step_to(64);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL press_valid got=%b exp=1", key_valid); end
    checks++; if (key_code !== 4'b1001) begin failures++; $display("FAIL press_code got=%b exp=1001", key_code); end
    step_to(84);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'b1001) begin failures++; $display("FAIL press_hold got=%b/%b exp=1/1001", key_valid, key_code); end
    key_ack = 1'b1;
    step_to(85);
    key_ack = 1'b0;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press_ack got=%b exp=0", key_valid); end
    step_to(100);
    keys = 16'h0;
    step_to(143);
    checks++; if (o_col !== 4'b1101) begin failures++; $display("FAIL press_relcol got=%b exp=1101", o_col); end
    step_to(144);
    checks++; if (o_col !== 4'b1011) begin failures++; $display("FAIL press_resume got=%b exp=1011", o_col); end
  endtask

  task automatic test_bounce();
    do_reset();
    step_to(20);
    keys[0*4+1] = 1'b1;
    step_to(36);
    keys = 16'h0;
    step_to(47);
    checks++; if (o_col !== 4'b1101) begin failures++; $display("FAIL bounce_frozen got=%b exp=1101", o_col); end
    step_to(48);
    checks++; if (o_col !== 4'b1011) begin failures++; $display("FAIL bounce_col2 got=%b exp=1011", o_col); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid48 got=%b exp=0", key_valid); end
    step_to(64);
    checks++; if (o_col !== 4'b0111) begin failures++; $display("FAIL bounce_col3 got=%b exp=0111", o_col); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid64 got=%b exp=0", key_valid); end
  endtask

  task automatic test_release_before_ack();
    do_reset();
    keys[1*4+3] = 1'b1;
    step_to(95);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rba_early got=%b exp=0", key_valid); end
    step_to(96);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'b0111) begin failures++; $display("FAIL rba_accept got=%b/%b exp=1/0111", key_valid, key_code); end
    step_to(100);
    keys = 16'h0;
    step_to(150);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'b0111) begin failures++; $display("FAIL rba_hold got=%b/%b exp=1/0111", key_valid, key_code); end
    checks++; if (o_col !== 4'b0111) begin failures++; $display("FAIL rba_frozen got=%b exp=0111", o_col); end
    step_to(200);
    key_ack = 1'b1;
    step_to(201);
    key_ack = 1'b0;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rba_ack got=%b exp=0", key_valid); end
    step_to(239);
    checks++; if (o_col !== 4'b0111) begin failures++; $display("FAIL rba_rel239 got=%b exp=0111", o_col); end
    step_to(240);
    checks++; if (o_col !== 4'b1110) begin failures++; $display("FAIL rba_rel240 got=%b exp=1110", o_col); end
  endtask

  task automatic test_two_rows();
    do_reset();
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    keys[2*4+2] = 1'b1;
    step_to(47);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL two_early got=%b exp=0", key_valid); end
    step_to(48);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'b0100) begin failures++; $display("FAIL two_code got=%b/%b exp=1/0100", key_valid, key_code); end
    step_to(59);
    key_ack = 1'b1;
    step_to(60);
    key_ack = 1'b0;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL two_ack got=%b exp=0", key_valid); end
    step_to(100);
    keys[1*4+0] = 1'b0;
    keys[3*4+0] = 1'b0;
    step_to(143);
    checks++; if (o_col !== 4'b1110 || key_valid !== 1'b0) begin failures++; $display("FAIL two_block got=%b/%b exp=1110/0", o_col, key_valid); end
    step_to(144);
    checks++; if (o_col !== 4'b1101) begin failures++; $display("FAIL two_resume got=%b exp=1101", o_col); end
    step_to(207);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL two_next_early got=%b exp=0", key_valid); end
    step_to(208);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'b1010) begin failures++; $display("FAIL two_next got=%b/%b exp=1/1010", key_valid, key_code); end
  endtask

  task automatic test_digitbuf();
    logic [31:0] exp_dig;
    int n;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      keys = 16'h0;
      keys[k] = 1'b1;
      n = 0;
      while (key_valid !== 1'b1 && n < 400) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(k)) begin failures++; $display("FAIL dig_key%0d got=%b/%h exp=1/%h", k, key_valid, key_code, 4'(k)); end
      key_ack = 1'b1;
      @(posedge clk);
      #1;
      key_ack = 1'b0;
      keys = 16'h0;
      repeat (80) @(posedge clk);
      #1;
    end
`ifdef KEYPAD_DIGITBUF_EN
    exp_dig = 32'h0000_0123;
`else
    exp_dig = 32'h0;
`endif
    checks++; if (o_digits !== exp_dig) begin failures++; $display("FAIL dig_hist got=%h exp=%h", o_digits, exp_dig); end
    keys[1] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL dig_press got=%b exp=1", key_valid); end
    rstn = 1'b0;
    #2;
    checks++; if (key_valid !== 1'b0 || o_digits !== 32'h0) begin failures++; $display("FAIL dig_rst got=%b/%h exp=0/0", key_valid, o_digits); end
    checks++; if (o_col !== 4'b1110 || key_code !== 4'h0) begin failures++; $display("FAIL dig_rst_col got=%b/%h exp=1110/0", o_col, key_code); end
    keys = 16'h0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ec       = 0;
    rstn     = 1'b0;
    key_ack  = 1'b0;
    keys     = 16'h0;
    row_ovr  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_before_ack();
    test_two_rows();
    test_digitbuf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
